// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared 8-bit bus; grants one of four sources for a fixed-length burst.
// Optional watchdog release of stalled bursts is built when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [7:0]         req_dest,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic               beat_valid,
    input  logic               beat_ready,
    output logic [3:0]         grant,
    output logic [1:0]         source_id,
    output logic [1:0]         destination_id,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_e;
    typedef enum logic [1:0] {R_NONE, R_DONE, R_ABORT, R_TIMEOUT} reason_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e             state_q, state_d;
    reason_e            reason_q, reason_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         dest_q, dest_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    logic       beat;
    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] cand;

    assign beat = beat_valid && beat_ready;

    // Scan last+1, last+2, ... so the previous owner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            reason_q <= R_NONE;
            last_q   <= 2'd3;
            owner_q  <= 2'd0;
            dest_q   <= 2'd0;
            len_q    <= '0;
            count_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            dest_q   <= dest_d;
            len_q    <= len_d;
            count_q  <= count_d;
`ifdef ARB_TIMEOUT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        last_d   = last_q;
        owner_d  = owner_q;
        dest_d   = dest_q;
        len_d    = len_q;
        count_d  = count_q;
`ifdef ARB_TIMEOUT_EN
        stall_d  = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                reason_d = R_NONE;
                if (win_found) begin
                    state_d = XFER;
                    owner_d = win_id;
                    last_d  = win_id;
                    dest_d  = req_dest[2*int'(win_id) +: 2];
                    len_d   = req_len[LEN_W*int'(win_id) +: LEN_W];
                    count_d = '0;
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            XFER: begin
                // A final beat wins over a simultaneous request drop.
                if (beat && count_q == len_q) begin
                    state_d  = RELEASE;
                    reason_d = R_DONE;
                    count_d  = '0;
                end else if (!req[owner_q]) begin
                    state_d  = RELEASE;
                    reason_d = R_ABORT;
                    count_d  = '0;
`ifdef ARB_TIMEOUT_EN
                end else if (!beat && stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = RELEASE;
                    reason_d = R_TIMEOUT;
                    count_d  = '0;
`endif
                end else begin
                    if (beat) count_d = count_q + LEN_W'(1);
`ifdef ARB_TIMEOUT_EN
                    stall_d = beat ? '0 : stall_q + STALL_W'(1);
`endif
                end
            end
            RELEASE: begin
                state_d  = IDLE;
                reason_d = R_NONE;
                count_d  = '0;
            end
            default: begin
                state_d  = IDLE;
                reason_d = R_NONE;
            end
        endcase
    end

    always_comb begin
        grant          = (state_q == XFER) ? (4'b0001 << owner_q) : 4'b0000;
        busy           = (state_q == XFER);
        source_id      = owner_q;
        destination_id = dest_q;
        done           = (state_q == RELEASE) && (reason_q == R_DONE);
        abort          = (state_q == RELEASE) && (reason_q == R_ABORT);
        timeout        = (state_q == RELEASE) && (reason_q == R_TIMEOUT);
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Grants ownership of the shared 8-bit data bus to one of four requesting components (2-bit source IDs 0..3).
- Sits directly upstream of each component's data_bus interface. It supplies the source/destination IDs and the grant ("ACK") that permit a component to drive bus_data.
- Arbitration is round-robin.
- A grant is held for a fixed-length burst of beats, counted on the valid/ready handshake, then released.

Parameters:
LEN_W, 4, width of per-source burst length field; burst length = field value + 1 beats (1..2^LEN_W)
TIMEOUT_CYCLES, 16, consecutive stalled XFER cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
req  input  4  per-source bus request, bit i = source i
req_dest  input  8  destination ID per source, bits [2i+1:2i] = source i
req_len  input  4*LEN_W  burst length-1 per source, bits [LEN_W*i+LEN_W-1:LEN_W*i]
beat_valid  input  1  owner presents a byte on bus_data this cycle
beat_ready  input  1  destination accepts the byte this cycle
grant  output  4  one-hot bus grant (ACK) to owner; 0 when bus idle
source_id  output  2  ID of current owner
destination_id  output  2  latched destination of current burst
busy  output  1  high while in XFER
done  output  1  1-cycle pulse: burst completed normally
abort  output  1  1-cycle pulse: owner dropped req mid-burst
timeout  output  1  1-cycle pulse: burst killed by watchdog

Behaviour:
- Reset is sampled only on a rising edge of clk, active when low. On reset, all outputs are 0, state is IDLE, beat count is 0, and the round-robin pointer last = 3 (source 0 has highest priority first).
- Reset mid-burst: grant drops the next edge. No done, abort or timeout pulse is produced.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - If req != 0, select the first set bit scanning last+1, last+2, ... mod 4.
  - Next edge: enter XFER with grant = onehot(winner) and source_id = winner.
  - Also latch destination_id from req_dest[winner], latch len from req_len[winner], and set last = winner.
  - Latency: req to grant is 1 cycle.
- XFER:
  - A beat counts when beat_valid && beat_ready.
  - The counter increments per beat. On the beat where count == len, go to RELEASE and pulse done in the RELEASE cycle.
  - If req[owner] is low (and the counting condition is not met this cycle), go to RELEASE and pulse abort.
  - Final beat coinciding with a req drop: treated as completion, so done is pulsed, not abort.
  - Requests from other sources never preempt the current owner.
- RELEASE:
  - grant = 0 and busy = 0; source_id and destination_id hold their last values.
  - Exactly one of done/abort/timeout is high; count resets to 0.
  - Always go to IDLE next cycle. Minimum gap between consecutive grants is 2 idle cycles (RELEASE, IDLE).
- The latched destination and len ignore changes on req_dest/req_len during the burst.
- Only one grant bit is ever high. grant is never high outside XFER.
- busy == (grant != 0).
- A single requester holding req continuously is re-granted after every RELEASE/IDLE pair.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A stall counter runs in XFER. It clears on any counted beat and increments otherwise.
  - When it reaches TIMEOUT_CYCLES, go to RELEASE and pulse timeout.
  - Priority: completion > abort > timeout.
- Undefined:
  - No stall counter; a stalled owner holds the bus indefinitely.
  - timeout is tied 0.

Test Plan:
- Single request: req=0001, req_len[3:0]=3, req_dest[1:0]=2, beat_valid=beat_ready=1 continuously -> grant=0001 one cycle after req, destination_id=2, 4 beats, done pulse in the following cycle, grant=0000 that cycle.
- Round-robin fairness: req=1111 held, all lens 0, beats always accepted -> grant order 0001, 0010, 0100, 1000, 0001, one RELEASE and one IDLE cycle between each.
- Backpressure: len=2, beat_ready toggles 1,0,1,0,1 with beat_valid=1 -> done only after the 3rd accepted beat (cycle 5 of XFER); a change on req_dest mid-burst does not change destination_id.
- Abort: source 2 granted with len=7, req[2] dropped after 3 beats -> abort pulse, grant=0000, no done; with req=0001 pending, source 0 granted 2 cycles later.
- Reset mid-burst: reset=0 during XFER with count=5 -> next edge grant=0, busy=0, all pulses 0; after release, source 0 wins first.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant source 1, beat_valid=0 for 16 cycles -> timeout pulse, grant released. Without the macro, the same stimulus leaves grant=0010 held for 100+ cycles and timeout stays 0.
